// File: rtl/adsr_pkg.sv
// ADSR envelope shared definitions: FSM state codes and Q2.30 amplitude constants.
// Latency: n/a (package only).
// Backpressure: n/a; the envelope advances only on the shared sample tick.
package adsr_pkg;

  // Legacy-compatible state encoding, kept as plain constants.
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  // Q2.30 full scale (1.0) and silence.
  localparam logic [31:0] ENV_MAX  = 32'h4000_0000;
  localparam logic [31:0] ENV_ZERO = 32'h0000_0000;

  // Sustain levels above full scale are pinned to full scale.
  function automatic logic [31:0] clamp_level(input logic [31:0] lvl);
    return (lvl > ENV_MAX) ? ENV_MAX : lvl;
  endfunction

endpackage

// File: rtl/adsr.sv
// ADSR envelope generator feeding the DDFS amplitude input (Q2.14 out, Q2.30 internal).
// Latency: o_env updates on the clock edge that samples i_en (1 cycle); o_done 1 cycle after RELEASE ends.
// Backpressure: none; steps only on i_en, priority i_start > i_stop > i_en.
//
// Ports:
//   i_clk, i_reset_n      clock, async active-low reset
//   i_en                  sample tick shared with the DDFS
//   i_start / i_stop      one-cycle key-on / key-off pulses
//   i_*_step, i_sustain_* Q2.30 slopes, sustain level, sustain length in ticks
//   o_env                 Q2.14 envelope (upper bits of the accumulator)
//   o_busy                state != IDLE
//   o_done                one-cycle pulse after RELEASE reaches zero
module adsr
  import adsr_pkg::*;
#(
  parameter int ENV_WIDTH = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_en,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [ENV_WIDTH-1:0] i_attack_step,
  input  logic [ENV_WIDTH-1:0] i_decay_step,
  input  logic [ENV_WIDTH-1:0] i_sustain_level,
  input  logic [ENV_WIDTH-1:0] i_sustain_time,
  input  logic [ENV_WIDTH-1:0] i_release_step,
  output logic [OUT_WIDTH-1:0] o_env,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [ENV_WIDTH-1:0] LVL_ONE  = ENV_WIDTH'(ENV_MAX);
  localparam logic [ENV_WIDTH-1:0] LVL_ZERO = ENV_WIDTH'(ENV_ZERO);

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [ENV_WIDTH-1:0] env_reg;
  logic [ENV_WIDTH-1:0] env_nxt;
  logic [ENV_WIDTH-1:0] cnt_reg;
  logic [ENV_WIDTH-1:0] cnt_nxt;
  logic                 done_nxt;

  // One extra bit on every sum so a wrap can never look like a small value.
  logic [ENV_WIDTH-1:0] sus_lvl;
  logic [ENV_WIDTH:0]   att_sum;
  logic [ENV_WIDTH:0]   dec_floor;
  logic [ENV_WIDTH:0]   cnt_inc;

  assign sus_lvl   = ENV_WIDTH'(clamp_level(32'(i_sustain_level)));
  assign att_sum   = {1'b0, env_reg} + {1'b0, i_attack_step};
  assign dec_floor = {1'b0, sus_lvl} + {1'b0, i_decay_step};
  assign cnt_inc   = {1'b0, cnt_reg} + {{ENV_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_nxt = state;
    env_nxt   = env_reg;
    cnt_nxt   = cnt_reg;
    done_nxt  = 1'b0;
    if (i_start) begin
      // Retrigger from the current level so there is no audible jump.
      state_nxt = ATTACK;
      cnt_nxt   = '0;
    end else if (i_stop) begin
      if (state == ATTACK || state == DECAY || state == SUSTAIN) begin
        state_nxt = RELEASE;
      end
    end else if (i_en) begin
      case (state)
        ATTACK: begin
          if (i_attack_step == '0 || att_sum >= {1'b0, LVL_ONE}) begin
            env_nxt   = LVL_ONE;
            state_nxt = DECAY;
          end else begin
            env_nxt = att_sum[ENV_WIDTH-1:0];
          end
        end
        DECAY: begin
          if (i_decay_step == '0 || {1'b0, env_reg} <= dec_floor) begin
            env_nxt   = sus_lvl;
            cnt_nxt   = '0;
            state_nxt = SUSTAIN;
          end else begin
            env_nxt = env_reg - i_decay_step;
          end
        end
        SUSTAIN: begin
          // A sustain time of 0 still spends one tick here.
          if (cnt_inc >= {1'b0, i_sustain_time}) begin
            state_nxt = RELEASE;
          end else begin
            cnt_nxt = cnt_inc[ENV_WIDTH-1:0];
          end
        end
        RELEASE: begin
          if (i_release_step == '0 || env_reg <= i_release_step) begin
            env_nxt   = LVL_ZERO;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            env_nxt = env_reg - i_release_step;
          end
        end
        default: begin
          state_nxt = IDLE;
          env_nxt   = LVL_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      env_reg <= LVL_ZERO;
      cnt_reg <= '0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      env_reg <= env_nxt;
      cnt_reg <= cnt_nxt;
      o_done  <= done_nxt;
    end
  end

  assign o_env  = env_reg[ENV_WIDTH-1 -: OUT_WIDTH];
  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_adsr.sv
// Self-checking bench for adsr: expected envelope values are queued per tick and
// compared by a monitor one cycle after the tick is sampled.
// Status checks (busy/done/reset) are made directly by the stimulus thread.
module tb_adsr;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_en;
  logic        i_start;
  logic        i_stop;
  logic [31:0] i_attack_step;
  logic [31:0] i_decay_step;
  logic [31:0] i_sustain_level;
  logic [31:0] i_sustain_time;
  logic [31:0] i_release_step;
  logic [15:0] o_env;
  logic        o_busy;
  logic        o_done;

  always #5 i_clk = ~i_clk;

  adsr dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_en            (i_en),
    .i_start         (i_start),
    .i_stop          (i_stop),
    .i_attack_step   (i_attack_step),
    .i_decay_step    (i_decay_step),
    .i_sustain_level (i_sustain_level),
    .i_sustain_time  (i_sustain_time),
    .i_release_step  (i_release_step),
    .o_env           (o_env),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  string       cur   = "init";
  logic [15:0] sb[$];
  logic        en_q;

  // Full attack/decay/sustain/release contour for the reference configuration.
  logic [15:0] full_exp [15] = '{
    16'h1000, 16'h2000, 16'h3000, 16'h4000,
    16'h3800, 16'h3000, 16'h2800, 16'h2000,
    16'h2000, 16'h2000, 16'h2000,
    16'h1800, 16'h1000, 16'h0800, 16'h0000
  };

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h, want %h", cur, tag, act, exp);
    end
  endtask

  // Monitor: every sampled tick must have a queued expectation.
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) en_q <= 1'b0;
    else            en_q <= i_en;
  end

  always @(negedge i_clk) begin
    if (en_q) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s/sb_underflow: got tick with no expectation, want queued value", cur);
      end else begin
        check("env", {16'h0, o_env}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic cfg(input logic [31:0] a, input logic [31:0] d, input logic [31:0] l,
                     input logic [31:0] t, input logic [31:0] r);
    i_attack_step   = a;
    i_decay_step    = d;
    i_sustain_level = l;
    i_sustain_time  = t;
    i_release_step  = r;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic tick(input logic [15:0] exp);
    sb.push_back(exp);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
  endtask

  task automatic tick_gap(input logic [15:0] exp);
    tick(exp);
    gap(3);
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    gap(2);
    i_reset_n = 1'b1;
    gap(1);
  endtask

  task automatic check_end();
    check("done_pulse", {31'b0, o_done}, 32'd1);
    check("busy_low",   {31'b0, o_busy}, 32'd0);
    @(negedge i_clk);
    check("done_once",  {31'b0, o_done}, 32'd0);
    gap(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0;
    i_en      = 1'b0;
    i_start   = 1'b0;
    i_stop    = 1'b0;
    cfg(32'h1000_0000, 32'h0800_0000, 32'h2000_0000, 32'd3, 32'h0800_0000);
    gap(2);

    cur = "reset";
    check("env",  {16'h0, o_env},   32'h0);
    check("busy", {31'b0, o_busy},  32'd0);
    check("done", {31'b0, o_done},  32'd0);
    i_reset_n = 1'b1;
    gap(2);
    check("idle_env", {16'h0, o_env}, 32'h0);

    // Full contour, one tick every four clocks.
    cur = "full";
    start_pulse();
    check("busy_start", {31'b0, o_busy}, 32'd1);
    check("env_start",  {16'h0, o_env},  32'h0);
    for (int k = 0; k < 15; k++) begin
      tick(full_exp[k]);
      if (k < 14) begin
        check("busy_mid", {31'b0, o_busy}, 32'd1);
        gap(3);
      end
    end
    check_end();

    // All slopes zero, sustain length zero.
    cur = "zero";
    cfg(32'h0, 32'h0, 32'h2000_0000, 32'd0, 32'h0);
    start_pulse();
    tick_gap(16'h4000);
    tick_gap(16'h2000);
    tick_gap(16'h2000);
    check("busy_sus", {31'b0, o_busy}, 32'd1);
    tick(16'h0000);
    check_end();

    // Retrigger from RELEASE at 0x1800.
    cur = "retrig";
    cfg(32'h1000_0000, 32'h0800_0000, 32'h2000_0000, 32'd3, 32'h0800_0000);
    start_pulse();
    for (int k = 0; k < 12; k++) tick_gap(full_exp[k]);
    start_pulse();
    check("env_hold", {16'h0, o_env}, 32'h1800);
    check("busy",     {31'b0, o_busy}, 32'd1);
    tick_gap(16'h2800);
    tick_gap(16'h3800);
    tick_gap(16'h4000);

    // Start and tick together: start wins, no step.
    cur = "coll_start_en";
    tick_gap(16'h3800);
    sb.push_back(16'h3800);
    i_start = 1'b1;
    i_en    = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_en    = 1'b0;
    gap(3);
    tick_gap(16'h4000);

    // Stop and start together: start wins, back to ATTACK.
    cur = "coll_stop_start";
    tick_gap(16'h3800);
    i_stop  = 1'b1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_stop  = 1'b0;
    i_start = 1'b0;
    check("env_hold", {16'h0, o_env}, 32'h3800);
    tick_gap(16'h4000);
    do_reset();

    // Key-off during ATTACK.
    cur = "keyoff";
    start_pulse();
    tick_gap(16'h1000);
    tick_gap(16'h2000);
    stop_pulse();
    check("env_hold", {16'h0, o_env}, 32'h2000);
    tick_gap(16'h1800);
    tick_gap(16'h1000);
    tick_gap(16'h0800);
    tick(16'h0000);
    check_end();

    // Oversized sustain level clamps to full scale.
    cur = "clamp";
    cfg(32'h1000_0000, 32'h0800_0000, 32'h7FFF_FFFF, 32'd1, 32'h0800_0000);
    start_pulse();
    tick_gap(16'h1000);
    tick_gap(16'h2000);
    tick_gap(16'h3000);
    tick_gap(16'h4000);
    tick_gap(16'h4000);
    tick_gap(16'h4000);
    tick_gap(16'h3800);
    do_reset();

    // Asynchronous reset in the middle of DECAY.
    cur = "async_rst";
    cfg(32'h1000_0000, 32'h0800_0000, 32'h2000_0000, 32'd3, 32'h0800_0000);
    start_pulse();
    for (int k = 0; k < 5; k++) tick_gap(full_exp[k]);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("env",  {16'h0, o_env},  32'h0);
    check("busy", {31'b0, o_busy}, 32'd0);
    check("done", {31'b0, o_done}, 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    gap(1);
    start_pulse();
    tick_gap(16'h1000);
    check("busy_after", {31'b0, o_busy}, 32'd1);

    cur = "end";
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adsr.md
Name: adsr

Overview:
- Envelope generator sitting directly upstream of the DDFS amplitude-modulation input; drives its 16-bit Q2.14 envelope port.
- Produces an attack/decay/sustain/release amplitude contour, advancing one step per sample tick.
- Shares the DDFS sample-enable strobe, so the envelope and the carrier advance on the same tick.
- Internal amplitude is 32-bit unsigned Q2.30 (1.0 = 0x4000_0000); the output is its upper 16 bits.

Parameters:
- ENV_WIDTH, 32: internal envelope accumulator width, Q2.30 format.
- OUT_WIDTH, 16: output width, Q2.14; equals the upper OUT_WIDTH bits of the accumulator.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset; one clock; asynchronous, active-low
- i_en  in  1  sample tick; the same strobe that enables the DDFS
- i_start  in  1  one-cycle key-on pulse; accepted on any cycle
- i_stop  in  1  one-cycle key-off pulse; forces release
- i_attack_step  in  32  Q2.30 increment per tick in ATTACK
- i_decay_step  in  32  Q2.30 decrement per tick in DECAY
- i_sustain_level  in  32  Q2.30 sustain amplitude; values > 0x4000_0000 are clamped to 0x4000_0000
- i_sustain_time  in  32  SUSTAIN duration in ticks
- i_release_step  in  32  Q2.30 decrement per tick in RELEASE
- o_env  out  16  Q2.14 envelope, registered
- o_busy  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle pulse on the RELEASE->IDLE transition

Behaviour:
- Reset: state=IDLE, env_reg=0, cnt_reg=0, o_env=0, o_busy=0, o_done=0.
- o_env = env_reg[31:16], registered. It changes on the clock edge that samples i_en; 1-cycle latency.
- Priority per cycle: i_start > i_stop > i_en step. Inputs ignored on a given cycle cause no step that cycle.
- i_start in any state: state=ATTACK, cnt_reg=0, env_reg unchanged (retrigger without a click). No step is applied that cycle even if i_en=1.
- i_stop in ATTACK, DECAY or SUSTAIN: state=RELEASE, env_reg held. No effect in IDLE or RELEASE.
- Steps are taken only on i_en=1. All add/subtract uses 33-bit arithmetic to detect overflow.
- IDLE: env_reg held at 0; no tick action.
- ATTACK tick:
  - If step==0 or env+step >= 0x4000_0000: env=0x4000_0000, go to DECAY.
  - Else env += step.
- DECAY tick (L = clamped sustain level):
  - If step==0 or env <= L+step: env=L, go to SUSTAIN, cnt=0.
  - Else env -= step.
- SUSTAIN tick:
  - If cnt+1 >= i_sustain_time: go to RELEASE.
  - Else cnt++.
  - SUSTAIN lasts max(i_sustain_time,1) ticks; env is held throughout.
- RELEASE tick:
  - If step==0 or env <= step: env=0, go to IDLE, o_done=1 next cycle for exactly one cycle.
  - Else env -= step.
- Step inputs are sampled live each tick. Changing them mid-phase alters the slope only; no other side effect.
- o_busy is combinational from the state register; it deasserts the same cycle o_done asserts.
- Asynchronous reset mid-envelope returns to the reset values immediately. The next i_start begins the attack from 0.

Decomposition:
- Package adsr_pkg:
  - State enum {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE}
  - ENV_MAX = 32'h4000_0000
  - ENV_ZERO
- No sub-module: one FSM plus the envelope/count datapath, about 150-200 lines.

Test Plan:
- Full cycle. Config: attack 0x1000_0000, decay 0x0800_0000, sustain 0x2000_0000, time 3, release 0x0800_0000. Pulse i_start, then i_en every 4 clocks. Expected o_env per tick:
  - 1000, 2000, 3000, 4000
  - 3800, 3000, 2800, 2000
  - 2000 x3
  - 1800, 1000, 0800, 0000
  - Then o_done pulses once and o_busy falls.
- Zero steps, sustain_time=0. Attack, decay and release steps all 0: 4000 after tick 1, 2000 after tick 2, one sustain tick, 0000 on tick 4, IDLE.
- Retrigger. i_start while in RELEASE at 0x1800: env holds 0x1800, then attack resumes 0x2800, 0x3800, 0x4000 (saturated).
- Key-off. i_stop during ATTACK at 0x2000: next ticks 1800, 1000, 0800, 0000, then o_done.
- Collisions.
  - i_start and i_en on the same cycle: no step, o_env unchanged.
  - i_stop and i_start on the same cycle: state=ATTACK.
  - sustain_level 0x7FFF_FFFF: clamped, decay ends at 4000.
- Reset. Assert i_reset_n low mid-DECAY: o_env=0, o_busy=0 asynchronously. After release of reset, i_start followed by a tick gives 1000.
